bcd_updown_display: RTL and testbench

// - Parametrised N-digit BCD up/down counter driven by two raw push-buttons, with multiplexed 7-segment output.
// - Single clock domain: debounce, edge detect, counting and display refresh all run on sysclock.
// - Adds wrap/saturate mode, overflow/underflow flags, leading-zero blanking and correct 0->9 borrow.
// - Sits between board buttons and the anode/segment pins of the display board.

---
 rtl/bcd_updown_display_pkg.sv | 37 +++
 rtl/bcd_updown_display_debounce_edge.sv | 48 ++++
 rtl/bcd_updown_display.sv | 133 +++++++++++++
 tb/tb_bcd_updown_display.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_updown_display_pkg.sv
// Shared constants for the BCD up/down display: digit width and the
// active-low 7-segment patterns, ordered {g,f,e,d,c,b,a}.
package bcd_updown_display_pkg;

   localparam int BCD_W = 4;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] seg7_encode(input logic [BCD_W-1:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_BLANK;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/bcd_updown_display_debounce_edge.sv
// One button path: 2-flop synchronizer, saturating stability counter and
// rising-edge detect on the debounced level. step is a 1-cycle pulse.
module debounce_edge #(
   parameter int DEBOUNCE_CYCLES = 65535
) (
   input  logic sysclock,
   input  logic reset,
   input  logic raw,
   output logic step
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             clean_prev_q, clean_prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clean;

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      cnt_d   = '0;
      if (sync2_q) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end
      // Gate with the synced input so a release drops clean without waiting for the counter.
      clean        = sync2_q && (cnt_q == CNT_MAX);
      clean_prev_d = clean;
      step         = clean & ~clean_prev_q;
   end

   always_ff @(posedge sysclock) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         cnt_q        <= '0;
         clean_prev_q <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         cnt_q        <= cnt_d;
         clean_prev_q <= clean_prev_d;
      end
   end

endmodule

// File: rtl/bcd_updown_display.sv
// N-digit BCD up/down counter fed by two debounced buttons, with wrap or
// saturate at the limits and a multiplexed active-low 7-segment output.
module bcd_updown_display
   import bcd_updown_display_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int DEBOUNCE_CYCLES = 65535,
   parameter int REFRESH_DIV     = 65536,
   parameter int BLANK_LEADING   = 0
) (
   input  logic                        sysclock,
   input  logic                        reset,
   input  logic                        btn_up,
   input  logic                        btn_down,
   input  logic                        mode_wrap,
   output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
   output logic                        overflow,
   output logic                        underflow,
   output logic [NUM_DIGITS-1:0]       anode,
   output logic [7:0]                  segs
);

   localparam int CW = BCD_W * NUM_DIGITS;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [RW-1:0] RF_LAST  = RW'(REFRESH_DIV - 1);

   logic step_up, step_down;

   debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .sysclock (sysclock),
      .reset    (reset),
      .raw      (btn_up),
      .step     (step_up)
   );

   debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .sysclock (sysclock),
      .reset    (reset),
      .raw      (btn_down),
      .step     (step_down)
   );

   logic [CW-1:0]         count_q, count_d, count_inc, count_dec;
   logic                  overflow_q, overflow_d, underflow_q, underflow_d;
   logic                  all9, all0;
   logic [RW-1:0]         refresh_q, refresh_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_DIGITS-1:0] blank;
   logic [BCD_W-1:0]      sel_digit;

   // Ripple carry/borrow: a digit moves only when every lower digit is at its limit.
   always_comb begin : ripple
      logic             cy, bw;
      logic [BCD_W-1:0] d;
      cy        = 1'b1;
      bw        = 1'b1;
      d         = '0;
      count_inc = count_q;
      count_dec = count_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = count_q[BCD_W*i +: BCD_W];
         if (cy) count_inc[BCD_W*i +: BCD_W] = (d == 4'd9) ? 4'd0 : d + 4'd1;
         if (bw) count_dec[BCD_W*i +: BCD_W] = (d == 4'd0) ? 4'd9 : d - 4'd1;
         cy = cy & (d == 4'd9);
         bw = bw & (d == 4'd0);
      end
      all9 = cy;
      all0 = bw;
   end

   always_comb begin
      count_d     = count_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (step_up && !step_down) begin
         overflow_d = all9;
         if (!all9 || mode_wrap) count_d = count_inc;
      end else if (step_down && !step_up) begin
         underflow_d = all0;
         if (!all0 || mode_wrap) count_d = count_dec;
      end
   end

   always_comb begin
      refresh_d = refresh_q + RW'(1);
      idx_d     = idx_q;
      if (refresh_q == RF_LAST) begin
         refresh_d = '0;
         idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
   end

   always_ff @(posedge sysclock) begin
      if (reset) begin
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         refresh_q   <= '0;
         idx_q       <= '0;
      end else begin
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         refresh_q   <= refresh_d;
         idx_q       <= idx_d;
      end
   end

   // Blank a digit when it and everything above it is zero; digit 0 always shows.
   always_comb begin : blanking
      logic z;
      z     = 1'b1;
      blank = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         z        = z & (count_q[BCD_W*i +: BCD_W] == 4'd0);
         blank[i] = (BLANK_LEADING != 0) && (i != 0) && z;
      end
   end

   always_comb begin
      sel_digit    = count_q[idx_q*BCD_W +: BCD_W];
      anode        = '1;
      anode[idx_q] = 1'b0;
      segs         = {1'b1, blank[idx_q] ? SEG_BLANK : seg7_encode(sel_digit)};
   end

   assign count_bcd = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_bcd_updown_display.sv
// Randomized press sequences against a decimal-integer model of the counter;
// a queue of expected {count, overflow, underflow} events is drained by a monitor.
module tb_bcd_updown_display;

   localparam int ND = 4;
   localparam int DB = 4;
   localparam int RD = 4;

   logic        sysclock = 1'b0;
   logic        reset, btn_up, btn_down, mode_wrap;
   logic [15:0] count_bcd;
   logic        overflow, underflow;
   logic [3:0]  anode;
   logic [7:0]  segs;

   always #5 sysclock = ~sysclock;

   bcd_updown_display #(
      .NUM_DIGITS      (ND),
      .DEBOUNCE_CYCLES (DB),
      .REFRESH_DIV     (RD),
      .BLANK_LEADING   (1)
   ) dut (
      .sysclock  (sysclock),
      .reset     (reset),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .mode_wrap (mode_wrap),
      .count_bcd (count_bcd),
      .overflow  (overflow),
      .underflow (underflow),
      .anode     (anode),
      .segs      (segs)
   );

   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic [17:0] exp_q[$];
   int          model_val = 0;
   bit          mon_en    = 1'b0;
   logic [15:0] prev_count;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int p;
      r = '0;
      p = v;
      for (int k = 0; k < 4; k++) begin
         r[4*k +: 4] = 4'(p % 10);
         p = p / 10;
      end
      return r;
   endfunction

   function automatic int pow10(input int k);
      int r;
      r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] seg_model(input int v, input int k);
      int d;
      if (k > 0 && v < pow10(k)) return 7'b1111111;
      d = (v / pow10(k)) % 10;
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_press(input bit up, input bit wrap);
      int nv;
      bit o, u;
      nv = model_val;
      o  = 1'b0;
      u  = 1'b0;
      if (up) begin
         if (model_val == 9999) begin o = 1'b1; nv = wrap ? 0 : 9999; end
         else nv = model_val + 1;
      end else begin
         if (model_val == 0) begin u = 1'b1; nv = wrap ? 9999 : 0; end
         else nv = model_val - 1;
      end
      exp_q.push_back({to_bcd(nv), o, u});
      model_val = nv;
   endtask

   task automatic press(input bit up, input bit down, input bit wrap);
      int hold, rel;
      hold = $urandom_range(8, 14);
      rel  = $urandom_range(4, 7);
      @(negedge sysclock);
      mode_wrap = wrap;
      if (up != down) model_press(up, wrap);
      btn_up   = up;
      btn_down = down;
      repeat (hold) @(negedge sysclock);
      btn_up    = 1'b0;
      btn_down  = 1'b0;
      mode_wrap = 1'($urandom_range(0, 1));
      repeat (rel) @(negedge sysclock);
   endtask

   task automatic do_reset();
      @(negedge sysclock);
      if (mon_en && model_val != 0) exp_q.push_back({16'h0000, 2'b00});
      model_val = 0;
      reset     = 1'b1;
      repeat (2) @(negedge sysclock);
      reset = 1'b0;
   endtask

   always @(negedge sysclock) begin
      if (mon_en) begin
         if (count_bcd !== prev_count || overflow || underflow) begin
            if (exp_q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_event: got count=%h ovf=%b unf=%b expected no event",
                        count_bcd, overflow, underflow);
            end else begin
               check("scoreboard", {14'd0, count_bcd, overflow, underflow}, {14'd0, exp_q.pop_front()});
            end
         end
         prev_count = count_bcd;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      bit   found;
      logic [3:0] pa;
      reset     = 1'b1;
      btn_up    = 1'b0;
      btn_down  = 1'b0;
      mode_wrap = 1'b1;
      repeat (3) @(negedge sysclock);
      reset = 1'b0;
      check("reset_count", {16'd0, count_bcd}, 32'h0);
      check("reset_flags", {30'd0, overflow, underflow}, 32'h0);
      check("reset_anode", {28'd0, anode}, 32'he);
      check("reset_segs", {24'd0, segs}, 32'hc0);
      prev_count = count_bcd;
      mon_en     = 1'b1;

      // Latency: first edge sampling the raw press is edge 1.
      model_press(1'b1, 1'b1);
      btn_up = 1'b1;
      lat    = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge sysclock);
         #1;
         if (lat == 0 && count_bcd == 16'h0001) lat = n;
      end
      check("press_latency", 32'(lat), 32'd7);
      @(negedge sysclock);
      btn_up = 1'b0;
      repeat (8) @(negedge sysclock);

      // Glitch shorter than the debounce window.
      btn_up = 1'b1;
      repeat (3) @(negedge sysclock);
      btn_up = 1'b0;
      repeat (12) @(negedge sysclock);
      check("glitch_ignored", {16'd0, count_bcd}, {16'd0, to_bcd(model_val)});

      repeat (98) press(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      press(1'b1, 1'b0, 1'b1);
      check("carry_0100", {16'd0, count_bcd}, 32'h0100);
      press(1'b0, 1'b1, 1'b1);
      check("borrow_0099", {16'd0, count_bcd}, 32'h0099);

      do_reset();
      press(1'b0, 1'b1, 1'b1);
      press(1'b1, 1'b0, 1'b1);
      press(1'b0, 1'b1, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b1, 1'b1);
      check("cancel_both", {16'd0, count_bcd}, 32'h9999);
      press(1'b0, 1'b1, 1'b0);

      do_reset();
      press(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         int sel;
         sel = $urandom_range(0, 4);
         press(sel < 2, sel >= 2 && sel < 4 || sel == 4, 1'($urandom_range(0, 1)));
      end

      do_reset();
      repeat (42) press(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      check("load_0042", {16'd0, count_bcd}, 32'h0042);

      found = 1'b0;
      pa    = anode;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge sysclock);
         if (pa == 4'b0111 && anode == 4'b1110) found = 1'b1;
         pa = anode;
      end
      check("walk_sync", {31'd0, found}, 32'd1);
      for (int c = 0; c < 16; c++) begin
         check("walk_anode", {28'd0, anode}, {28'd0, ~(4'b0001 << (c / 4))});
         check("walk_segs", {24'd0, segs}, {24'd0, 1'b1, seg_model(model_val, c / 4)});
         @(negedge sysclock);
      end

      repeat (9) @(negedge sysclock);
      exp_q.push_back({16'h0000, 2'b00});
      model_val = 0;
      reset     = 1'b1;
      @(posedge sysclock);
      #1;
      check("midwalk_reset_anode", {28'd0, anode}, 32'he);
      check("midwalk_reset_count", {16'd0, count_bcd}, 32'h0);
      @(negedge sysclock);
      reset = 1'b0;

      repeat (20) @(negedge sysclock);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
